card_dealer: RTL and testbench

Downstream stage of the shuffler. Accepts a freshly shuffled 52-card deck one card index at a time, stores it, and deals cards in order on request to the blackjack controller. Each dealt card comes with its blackjack point value. The block tracks how many cards are left and re-requests a shuffle when the controller starts a new round on a low deck. It also rejects and flags corrupt input: duplicate or out-of-range card indices.

---
 rtl/card_dealer_if.sv | 31 +++
 rtl/card_dealer.sv | 162 ++++++++++++++++
 tb/tb_card_dealer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// card_dealer_if: groups the shuffler-facing input handshake and the
// controller-facing deal bus of card_dealer.
//   slave  : the dealer (receives cards/requests, drives deal results)
//   master : the environment (shuffler + blackjack controller)
interface card_dealer_if;
  logic       shuffleFlag;  // dealer wants a fresh deck
  logic [5:0] cardIn;       // card index from shuffler
  logic       cardInValid;
  logic       cardInReady;
  logic       dealReq;      // next card please
  logic       newRound;     // controller round boundary
  logic [5:0] card;         // dealt card index
  logic [3:0] cardValue;    // blackjack value 1..10
  logic       isAce;
  logic       cardValid;    // one-cycle pulse per dealt card
  logic [5:0] dealsLeft;
  logic       lowDeck;
  logic       dupError;     // sticky corrupt-input flag

  modport slave (
    input  cardIn, cardInValid, dealReq, newRound,
    output shuffleFlag, cardInReady, card, cardValue, isAce, cardValid,
           dealsLeft, lowDeck, dupError
  );

  modport master (
    output cardIn, cardInValid, dealReq, newRound,
    input  shuffleFlag, cardInReady, card, cardValue, isAce, cardValid,
           dealsLeft, lowDeck, dupError
  );
endinterface

// File: rtl/card_dealer.sv
// card_dealer: stores a shuffled deck arriving one index per cycle, then
// deals it in order with blackjack point values. Rejects duplicate or
// out-of-range indices (sticky dupError) and asks for a reshuffle when a new
// round starts on a low or empty deck.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - card_dealer_if.slave: card input handshake, deal request/result,
//          deck status flags
module card_dealer #(
  parameter int DECK_SIZE    = 52,
  parameter int RESHUFFLE_AT = 15
) (
  input  logic         clk,
  input  logic         rst,
  card_dealer_if.slave bus
);

  localparam logic [5:0] DECK_N  = 6'(DECK_SIZE);
  localparam logic [5:0] LAST_WR = 6'(DECK_SIZE - 1);
  localparam logic [5:0] LOW_TH  = 6'(RESHUFFLE_AT);

  typedef enum logic [1:0] {FILL, READY, EMPTY} state_t;

  state_t                 state_q, state_d;
  logic [DECK_SIZE-1:0]   used_q, used_d;
  logic [5:0]             deck_q [DECK_SIZE];
  logic [5:0]             wrPtr_q, wrPtr_d;
  logic [5:0]             rdPtr_q, rdPtr_d;
  logic [5:0]             dealsLeft_q, dealsLeft_d;
  logic                   lowDeck_q, lowDeck_d;
  logic                   dupError_q, dupError_d;
  logic [5:0]             card_q, card_d;
  logic [3:0]             value_q, value_d;
  logic                   ace_q, ace_d;
  logic                   cardValid_q, cardValid_d;
  logic                   fill_q;       // registered FILL decode
  logic                   deck_we;
  logic [63:0]            used_ext;
  logic                   in_range, legal;

  // Blackjack value from rank = card mod 13; ace counts as 1.
  function automatic logic [4:0] card_val(input logic [5:0] c);
    logic [5:0] rank;
    rank = 6'(c % 6'd13);
    if (rank == 6'd0)      card_val = {4'd1, 1'b1};
    else if (rank <= 6'd8) card_val = {4'(rank + 6'd1), 1'b0};
    else                   card_val = {4'd10, 1'b0};
  endfunction

  // Zero-extend so an out-of-range index never reads past the used[] vector.
  assign used_ext = 64'(used_q);
  assign in_range = (bus.cardIn < DECK_N);
  assign legal    = in_range && !used_ext[bus.cardIn];

  always_comb begin
    state_d     = state_q;
    used_d      = used_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    dealsLeft_d = dealsLeft_q;
    dupError_d  = dupError_q;
    card_d      = card_q;
    value_d     = value_q;
    ace_d       = ace_q;
    cardValid_d = 1'b0;
    deck_we     = 1'b0;

    case (state_q)
      FILL: begin
        if (bus.cardInValid && fill_q) begin
          if (legal) begin
            deck_we                = 1'b1;
            used_d[bus.cardIn]     = 1'b1;
            wrPtr_d                = wrPtr_q + 6'd1;
            if (wrPtr_q == LAST_WR) begin
              state_d     = READY;
              dealsLeft_d = DECK_N;
              rdPtr_d     = 6'd0;
            end
          end else begin
            dupError_d = 1'b1;
          end
        end
      end
      READY: begin
        // A reshuffle-triggering newRound pre-empts a same-cycle deal.
        if (bus.newRound && lowDeck_q) begin
          state_d     = FILL;
          used_d      = '0;
          wrPtr_d     = 6'd0;
          dealsLeft_d = 6'd0;
        end else if (bus.dealReq) begin
          card_d              = deck_q[rdPtr_q];
          {value_d, ace_d}    = card_val(deck_q[rdPtr_q]);
          cardValid_d         = 1'b1;
          rdPtr_d             = rdPtr_q + 6'd1;
          dealsLeft_d         = dealsLeft_q - 6'd1;
          if (dealsLeft_q == 6'd1) state_d = EMPTY;
        end
      end
      EMPTY: begin
        if (bus.newRound) begin
          state_d     = FILL;
          used_d      = '0;
          wrPtr_d     = 6'd0;
          dealsLeft_d = 6'd0;
        end
      end
      default: state_d = FILL;
    endcase

    // lowDeck only means something once a deck is loaded.
    lowDeck_d = (state_d != FILL) && (dealsLeft_d <= LOW_TH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      fill_q      <= 1'b1;
      used_q      <= '0;
      wrPtr_q     <= 6'd0;
      rdPtr_q     <= 6'd0;
      dealsLeft_q <= 6'd0;
      lowDeck_q   <= 1'b0;
      dupError_q  <= 1'b0;
      card_q      <= 6'd0;
      value_q     <= 4'd0;
      ace_q       <= 1'b0;
      cardValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= (state_d == FILL);
      used_q      <= used_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      dealsLeft_q <= dealsLeft_d;
      lowDeck_q   <= lowDeck_d;
      dupError_q  <= dupError_d;
      card_q      <= card_d;
      value_q     <= value_d;
      ace_q       <= ace_d;
      cardValid_q <= cardValid_d;
    end
  end

  // Deck storage needs no reset; contents are rewritten on every fill.
  always_ff @(posedge clk) begin
    if (rst && deck_we) deck_q[wrPtr_q] <= bus.cardIn;
  end

  assign bus.shuffleFlag = fill_q;
  assign bus.cardInReady = fill_q;
  assign bus.card        = card_q;
  assign bus.cardValue   = value_q;
  assign bus.isAce       = ace_q;
  assign bus.cardValid   = cardValid_q;
  assign bus.dealsLeft   = dealsLeft_q;
  assign bus.lowDeck     = lowDeck_q;
  assign bus.dupError    = dupError_q;

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  card_dealer_if bus();

  card_dealer #(.DECK_SIZE(52), .RESHUFFLE_AT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge and outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference blackjack value by repeated subtraction.
  function automatic int ref_val(input int c);
    int r;
    r = c;
    while (r >= 13) r -= 13;
    if (r == 0) return 1;
    if (r <= 8) return r + 1;
    return 10;
  endfunction

  task automatic feed(input int c);
    bus.cardIn      = 6'(c);
    bus.cardInValid = 1'b1;
    step();
    bus.cardInValid = 1'b0;
  endtask

  // Idle cycle with junk on cardIn and valid low.
  task automatic gap(input int junk);
    bus.cardIn      = 6'(junk);
    bus.cardInValid = 1'b0;
    step();
  endtask

  task automatic deal_check(input string tag, input int exp_card, input int exp_left);
    bus.dealReq = 1'b1;
    step();
    bus.dealReq = 1'b0;
    check({tag, ".card"},  32'(bus.card), 32'(exp_card));
    check({tag, ".value"}, 32'(bus.cardValue), 32'(ref_val(exp_card)));
    check({tag, ".ace"},   32'(bus.isAce), 32'(ref_val(exp_card) == 1));
    check({tag, ".valid"}, 32'(bus.cardValid), 32'd1);
    check({tag, ".left"},  32'(bus.dealsLeft), 32'(exp_left));
    check({tag, ".low"},   32'(bus.lowDeck), 32'(exp_left <= 15));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".shuffle"}, 32'(bus.shuffleFlag), 32'd1);
    check({tag, ".ready"},   32'(bus.cardInReady), 32'd1);
    check({tag, ".card"},    32'(bus.card), 32'd0);
    check({tag, ".value"},   32'(bus.cardValue), 32'd0);
    check({tag, ".ace"},     32'(bus.isAce), 32'd0);
    check({tag, ".valid"},   32'(bus.cardValid), 32'd0);
    check({tag, ".left"},    32'(bus.dealsLeft), 32'd0);
    check({tag, ".low"},     32'(bus.lowDeck), 32'd0);
    check({tag, ".dup"},     32'(bus.dupError), 32'd0);
  endtask

  // Deck order after the duplicate test: 5,0,1,2,3,4,6,7,...,51
  function automatic int dup_deck(input int k);
    if (k == 0) return 5;
    if (k <= 5) return k - 1;
    return k;
  endfunction

  initial begin
    rst             = 1'b0;
    bus.cardIn      = 6'd0;
    bus.cardInValid = 1'b0;
    bus.dealReq     = 1'b0;
    bus.newRound    = 1'b0;

    // ---- reset ----
    step();
    step();
    check_reset_vals("rst");
    rst = 1'b1;

    // ---- full fill 51..0 then deal all ----
    for (int c = 51; c >= 0; c--) feed(c);
    check("fill1.shuffle", 32'(bus.shuffleFlag), 32'd0);
    check("fill1.ready",   32'(bus.cardInReady), 32'd0);
    check("fill1.left",    32'(bus.dealsLeft), 32'd52);
    check("fill1.low",     32'(bus.lowDeck), 32'd0);
    check("fill1.dup",     32'(bus.dupError), 32'd0);
    for (int i = 0; i < 52; i++) begin
      deal_check($sformatf("deal1_%0d", i), 51 - i, 51 - i);
      if (51 - i == 51) check("val51",   32'(bus.cardValue), 32'd10);
      if (51 - i == 39) check("ace39",   32'(bus.isAce), 32'd1);
      if (51 - i == 40) check("val40",   32'(bus.cardValue), 32'd2);
    end
    // EMPTY: extra request gives no pulse, outputs hold
    bus.dealReq = 1'b1;
    step();
    step();
    bus.dealReq = 1'b0;
    check("empty.valid", 32'(bus.cardValid), 32'd0);
    check("empty.card",  32'(bus.card), 32'd0);
    check("empty.left",  32'(bus.dealsLeft), 32'd0);
    check("empty.low",   32'(bus.lowDeck), 32'd1);
    check("empty.shuf",  32'(bus.shuffleFlag), 32'd0);
    // cardIn ignored outside FILL: no dupError
    feed(3);
    check("empty.nodup", 32'(bus.dupError), 32'd0);

    // ---- newRound in EMPTY -> FILL ----
    bus.newRound = 1'b1;
    step();
    bus.newRound = 1'b0;
    check("nr_empty.shuf",  32'(bus.shuffleFlag), 32'd1);
    check("nr_empty.ready", 32'(bus.cardInReady), 32'd1);
    check("nr_empty.low",   32'(bus.lowDeck), 32'd0);

    // ---- duplicate rejection ----
    feed(5);
    check("dup.first", 32'(bus.dupError), 32'd0);
    feed(5);
    check("dup.second", 32'(bus.dupError), 32'd1);
    feed(60);
    check("dup.range", 32'(bus.dupError), 32'd1);
    for (int c = 0; c < 52; c++) begin
      if (c != 5) feed(c);
      if (c == 50) check("dup.notyet", 32'(bus.shuffleFlag), 32'd1);
    end
    check("dup.sticky", 32'(bus.dupError), 32'd1);
    check("dup.ready",  32'(bus.shuffleFlag), 32'd0);
    check("dup.left",   32'(bus.dealsLeft), 32'd52);
    for (int k = 0; k < 36; k++) deal_check($sformatf("deal2_%0d", k), dup_deck(k), 51 - k);

    // ---- newRound with dealsLeft=16: deal served ----
    bus.newRound = 1'b1;
    bus.dealReq  = 1'b1;
    step();
    bus.newRound = 1'b0;
    bus.dealReq  = 1'b0;
    check("nr16.valid", 32'(bus.cardValid), 32'd1);
    check("nr16.card",  32'(bus.card), 32'd36);
    check("nr16.left",  32'(bus.dealsLeft), 32'd15);
    check("nr16.low",   32'(bus.lowDeck), 32'd1);
    check("nr16.shuf",  32'(bus.shuffleFlag), 32'd0);

    // ---- newRound with lowDeck: reshuffle wins over deal ----
    bus.newRound = 1'b1;
    bus.dealReq  = 1'b1;
    step();
    bus.newRound = 1'b0;
    bus.dealReq  = 1'b0;
    check("nrlow.valid", 32'(bus.cardValid), 32'd0);
    check("nrlow.shuf",  32'(bus.shuffleFlag), 32'd1);
    check("nrlow.ready", 32'(bus.cardInReady), 32'd1);
    check("nrlow.left",  32'(bus.dealsLeft), 32'd0);
    check("nrlow.low",   32'(bus.lowDeck), 32'd0);
    check("nrlow.card",  32'(bus.card), 32'd36);

    // ---- reset mid-fill, with gaps and deal requests in FILL ----
    for (int c = 0; c < 20; c++) begin
      feed(c);
      if (c % 3 == 0) gap(60);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_vals("rst_mid");

    // refill 0..51 with backpressure gaps; junk on idle cycles is ignored
    for (int c = 0; c < 52; c++) begin
      if (c % 4 == 1) gap(0);
      if (c % 7 == 2) begin
        bus.dealReq = 1'b1;
        gap(62);
        bus.dealReq = 1'b0;
        check("fill3.nodeal", 32'(bus.cardValid), 32'd0);
      end
      feed(c);
      if (c == 50) check("fill3.need52", 32'(bus.shuffleFlag), 32'd1);
    end
    check("fill3.ready", 32'(bus.shuffleFlag), 32'd0);
    check("fill3.left",  32'(bus.dealsLeft), 32'd52);
    check("fill3.dup",   32'(bus.dupError), 32'd0);
    // cardIn in READY is ignored (duplicate value, no error)
    feed(3);
    feed(63);
    check("ready.nodup", 32'(bus.dupError), 32'd0);
    check("ready.left",  32'(bus.dealsLeft), 32'd52);
    deal_check("deal3_0", 0, 51);
    deal_check("deal3_1", 1, 50);
    step();
    check("deal3.pulse", 32'(bus.cardValid), 32'd0);
    check("deal3.hold",  32'(bus.card), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
